// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline-stage registers.
//   pipe_state_t    : stage occupancy state (empty / one entry / two entries)
//   PIPE_NOP_BUBBLE : 64-bit NOP encoding that CPU stages use as their bubble
//   pipe_occupancy  : maps a stage state to its entry count (0, 1 or 2)
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_FULL  = 2'd1,
    PS_SKID  = 2'd2
  } pipe_state_t;

  // RISC-V canonical NOP (addi x0, x0, 0), zero-extended to 64 bits.
  localparam logic [63:0] PIPE_NOP_BUBBLE = 64'h0000_0000_0000_0013;

  function automatic logic [1:0] pipe_occupancy(input pipe_state_t s);
    logic [1:0] n;
    n = 2'd0;
    case (s)
      PS_EMPTY: n = 2'd0;
      PS_FULL:  n = 2'd1;
      PS_SKID:  n = 2'd2;
      default:  n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// Enable-gated payload register with asynchronous active-high reset.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, loads RST_VAL
//   en    : load d on the next rising edge
//   d     : next value
//   q     : registered value
module pipe_data_reg #(
  parameter int unsigned           WIDTH   = 64,
  parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with valid/ready handshake, one-entry skid buffer
// and synchronous flush. The main entry drives out_data; the skid entry
// catches the beat that was already in flight when out_ready fell, so
// in_ready can be registered and still lose nothing.
//   clk       : rising-edge clock
//   reset     : asynchronous active-high reset, empties the stage
//   flush     : synchronous squash of both entries (input in same cycle dropped)
//   in_valid  : upstream offers in_data
//   in_ready  : stage can accept (function of state only)
//   in_data   : upstream payload
//   out_valid : out_data holds a live entry (function of state only)
//   out_ready : downstream consumes this cycle
//   out_data  : main entry payload
//   count     : occupancy 0, 1 or 2
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH  = 64,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  pipe_state_t      state;
  pipe_state_t      state_nxt;
  logic             acc;
  logic             deq;
  logic             main_en;
  logic             skid_en;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_d;
  logic [WIDTH-1:0] skid_q;

  assign in_ready  = (state != PS_SKID);
  assign out_valid = (state != PS_EMPTY);
  assign count     = pipe_occupancy(state);

  assign acc = in_valid & in_ready;
  assign deq = out_valid & out_ready;

  always_comb begin
    state_nxt = state;
    main_en   = 1'b0;
    main_d    = in_data;
    skid_en   = 1'b0;
    skid_d    = in_data;
    if (flush) begin
      state_nxt = PS_EMPTY;
      main_en   = 1'b1;
      main_d    = BUBBLE;
      skid_en   = 1'b1;
      skid_d    = BUBBLE;
    end else begin
      case (state)
        PS_EMPTY: begin
          if (acc) begin
            main_en   = 1'b1;
            state_nxt = PS_FULL;
          end
        end
        PS_FULL: begin
          if (acc && deq) begin
            main_en = 1'b1;
          end else if (acc) begin
            skid_en   = 1'b1;
            state_nxt = PS_SKID;
          end else if (deq) begin
            // main keeps its stale payload; only the state marks it dead
            state_nxt = PS_EMPTY;
          end
        end
        PS_SKID: begin
          if (deq) begin
            main_en   = 1'b1;
            main_d    = skid_q;
            skid_en   = 1'b1;
            skid_d    = BUBBLE;
            state_nxt = PS_FULL;
          end
        end
        default: state_nxt = PS_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= PS_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  pipe_data_reg #(
    .WIDTH   (WIDTH),
    .RST_VAL (BUBBLE)
  ) u_main (
    .clk   (clk),
    .reset (reset),
    .en    (main_en),
    .d     (main_d),
    .q     (out_data)
  );

  pipe_data_reg #(
    .WIDTH   (WIDTH),
    .RST_VAL (BUBBLE)
  ) u_skid (
    .clk   (clk),
    .reset (reset),
    .en    (skid_en),
    .d     (skid_d),
    .q     (skid_q)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed scenarios followed by a
// long randomised run, all checked against a queue model of the stage.
module tb_pipe_skid_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [1:0]  count;

  logic        flush8;
  logic        in_valid8;
  logic        in_ready8;
  logic [7:0]  in_data8;
  logic        out_valid8;
  logic        out_ready8;
  logic [7:0]  out_data8;
  logic [1:0]  count8;

  int total = 0;
  int bad   = 0;

  // Reference model: entries held by the stage, oldest first, plus the
  // payload the main register is expected to show.
  logic [63:0] q[$];
  logic [63:0] exp_out;

  always #5 clk = ~clk;

  pipe_skid_reg dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  pipe_skid_reg #(
    .WIDTH  (8),
    .BUBBLE (8'hA5)
  ) dut8 (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush8),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .in_data   (in_data8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .out_data  (out_data8),
    .count     (count8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_main(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(q.size() > 0));
    chk({tag, "_in_ready"},  64'(in_ready),  64'(q.size() < 2));
    chk({tag, "_count"},     64'(count),     64'(q.size()));
    chk({tag, "_out_data"},  out_data,       exp_out);
  endtask

  // Called at a falling edge; drives inputs, lets one rising edge pass,
  // advances the model and returns at the next falling edge.
  task automatic step(input logic iv, input logic [63:0] d, input logic ordy, input logic fl);
    logic acc;
    logic deq;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    acc = iv && (q.size() < 2);
    deq = ordy && (q.size() > 0);
    @(posedge clk);
    if (fl) begin
      q.delete();
      exp_out = '0;
    end else begin
      if (deq) void'(q.pop_front());
      if (acc) q.push_back(d);
      if (q.size() > 0) exp_out = q[0];
    end
    @(negedge clk);
  endtask

  initial begin
    logic        iv;
    logic        ordy;
    logic        fl;
    logic [63:0] d;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    flush8 = 1'b0; in_valid8 = 1'b0; in_data8 = '0; out_ready8 = 1'b0;
    q.delete();
    exp_out = '0;

    #12;
    check_main("reset");
    chk("reset_out_data8", 64'(out_data8), 64'h0A5);
    chk("reset_out_valid8", 64'(out_valid8), 64'h0);
    @(negedge clk);
    reset = 1'b0;

    // Back-to-back stream at full throughput
    step(1'b1, 64'h11, 1'b1, 1'b0); check_main("stream_a"); chk("stream_a_val", out_data, 64'h11);
    step(1'b1, 64'h22, 1'b1, 1'b0); check_main("stream_b"); chk("stream_b_val", out_data, 64'h22);
    step(1'b1, 64'h33, 1'b1, 1'b0); check_main("stream_c"); chk("stream_c_val", out_data, 64'h33);
    step(1'b0, 64'h0,  1'b1, 1'b0); check_main("stream_drain");

    // Backpressure into the skid entry
    step(1'b1, 64'h11, 1'b1, 1'b0); check_main("bp_fill");
    step(1'b1, 64'h22, 1'b0, 1'b0); check_main("bp_skid");
    chk("bp_skid_count", 64'(count), 64'd2);
    chk("bp_skid_in_ready", 64'(in_ready), 64'd0);
    step(1'b1, 64'h99, 1'b0, 1'b0); check_main("bp_hold");
    chk("bp_hold_val", out_data, 64'h11);
    step(1'b0, 64'h0,  1'b1, 1'b0); check_main("bp_pop1");
    chk("bp_pop1_val", out_data, 64'h22);
    step(1'b0, 64'h0,  1'b1, 1'b0); check_main("bp_pop2");

    // Flush while two entries are held, with an input offered
    step(1'b1, 64'h11, 1'b0, 1'b0);
    step(1'b1, 64'h22, 1'b0, 1'b0); check_main("fl_skid");
    step(1'b1, 64'h44, 1'b0, 1'b1); check_main("fl_after");
    chk("fl_after_out_data", out_data, 64'h0);
    step(1'b0, 64'h0,  1'b1, 1'b0); check_main("fl_idle");
    chk("fl_idle_out_valid", 64'(out_valid), 64'd0);

    // Asynchronous reset landing mid-cycle with both entries held
    step(1'b1, 64'h11, 1'b0, 1'b0);
    step(1'b1, 64'h22, 1'b0, 1'b0); check_main("ar_skid");
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    #2 reset = 1'b1;
    #1;
    q.delete();
    exp_out = '0;
    check_main("ar_async");
    chk("ar_async_out_valid", 64'(out_valid), 64'd0);
    #1 reset = 1'b0;
    @(negedge clk);
    step(1'b1, 64'h55, 1'b1, 1'b0); check_main("ar_first");
    chk("ar_first_val", out_data, 64'h55);
    step(1'b0, 64'h0,  1'b1, 1'b0); check_main("ar_alone");

    // Narrow instance with a non-zero bubble
    in_valid8 = 1'b1; in_data8 = 8'h3C; out_ready8 = 1'b0;
    @(negedge clk);
    chk("w8_load_val", 64'(out_data8), 64'h03C);
    chk("w8_load_valid", 64'(out_valid8), 64'd1);
    in_valid8 = 1'b0; flush8 = 1'b1;
    @(negedge clk);
    flush8 = 1'b0;
    chk("w8_flush_val", 64'(out_data8), 64'h0A5);
    chk("w8_flush_valid", 64'(out_valid8), 64'd0);
    chk("w8_flush_count", 64'(count8), 64'd0);

    // Randomised traffic against the queue model
    for (int i = 0; i < 12000; i++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 1) != 0);
      fl   = ($urandom_range(0, 39) == 0);
      d    = {$urandom(), $urandom()};
      step(iv, d, ordy, fl);
      check_main("rand");
      chk("rand_count_le2", 64'(count <= 2'd2), 64'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised pipeline-stage register with valid/ready handshaking, a one-entry skid buffer and a synchronous flush. It replaces bare enable-gated stage registers between CPU pipeline stages, such as IF/ID and ID/EX. With it, a downstream stall propagates upstream one cycle late without losing data, and a branch or exception flush empties the stage in one cycle. Data goes through in order, at full throughput, and no ready signal has a combinational path from output to input.

## Interface
- WIDTH, 64, payload width in bits (≥1)
- BUBBLE, '0 (WIDTH bits), value loaded into the data registers on reset and flush (the NOP encoding)

- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state immediately
- flush  input  1  synchronous squash of all held entries
- in_valid  input  1  upstream offers in_data
- in_ready  output  1  stage can accept; registered, depends only on state
- in_data  input  WIDTH  upstream payload
- out_valid  output  1  out_data holds a live entry
- out_ready  input  1  downstream consumes this cycle
- out_data  output  WIDTH  payload; equals BUBBLE whenever out_valid=0 after reset or flush
- count  output  2  occupancy: 0, 1 or 2

## Operation
- State is held in two entries: main (drives out_data) and skid. The FSM state is EMPTY, FULL or SKID.
- Handshakes:
  - Input transfer (acc) = in_valid & in_ready.
  - Output transfer (deq) = out_valid & out_ready.
- Combinational outputs:
  - in_ready = (state != SKID).
  - out_valid = (state != EMPTY).
  - count = 0, 1 or 2 for EMPTY, FULL and SKID respectively.
- Transitions (no flush):
  - EMPTY, acc: main ← in_data, go to FULL.
  - EMPTY, no acc: stay in EMPTY.
  - FULL, acc & deq: main ← in_data, stay in FULL.
  - FULL, acc & !deq: skid ← in_data, go to SKID.
  - FULL, !acc & deq: main keeps its value, go to EMPTY.
  - FULL, neither: hold.
  - SKID, deq: main ← skid, skid ← BUBBLE, go to FULL. No acc is possible in SKID because in_ready=0.
  - SKID, !deq: hold both entries.
- Flush has priority over every transition:
  - Next state is EMPTY; main ← BUBBLE, skid ← BUBBLE.
  - An input offered in the flush cycle is discarded, even though in_ready=1.
  - An output deq in the flush cycle completes normally for the consumer.
- Data registers load only on the enables listed above; they are not written on idle cycles.
- Ordering is strictly FIFO: the skid entry is never output before main.

## Timing
- Reset values: state=EMPTY, out_valid=0, in_ready=1, count=0, out_data=BUBBLE, skid=BUBBLE.
- Reset takes effect asynchronously. The first transfer can occur on the first rising edge after reset deasserts.
- Latency: one cycle from acc to out_valid when the stage is empty.
- Throughput: one transfer per cycle while out_ready stays 1.
- Backpressure: out_ready falling is seen at in_ready one cycle later. The in-flight beat lands in skid, so nothing is dropped.
- in_ready and out_valid are pure functions of registered state. There is no combinational in→out path on the handshake signals.
- Reset asserted mid-operation discards both entries immediately.
- flush and reset together: reset wins (same end state).

## Structure
- pipe_pkg holds the shared stage definitions:
  - typedef enum logic [1:0] {PS_EMPTY, PS_FULL, PS_SKID} pipe_state_t;
  - constant PIPE_NOP_BUBBLE (64-bit NOP encoding), used as the BUBBLE default by CPU stages.
- Sub-module pipe_data_reg #(WIDTH, RST_VAL): WIDTH-wide register with enable and asynchronous active-high reset to RST_VAL. It is instantiated twice, for main and skid.
- Next-state and enable logic live in pipe_skid_reg itself.

## Test plan
- Reset, then stream A=0x11, B=0x22 and C=0x33 on consecutive cycles with out_ready=1 → out_data shows 0x11, 0x22, 0x33 on cycles 1–3; count stays 1; in_ready stays 1.
- While FULL with 0x11, drop out_ready for 2 cycles as 0x22 is offered → skid=0x22, count=2, in_ready=0 the next cycle. Raise out_ready → outputs 0x11 then 0x22 in order, with no loss or duplication.
- In SKID, assert flush with in_valid=1 and in_data=0x44 → next cycle: out_valid=0, count=0, out_data=BUBBLE, in_ready=1, and 0x44 never appears at the output.
- Assert reset asynchronously mid-cycle while count=2 → out_valid=0 and in_ready=1 before the next edge; the first post-reset beat 0x55 appears alone.
- Randomised in_valid/out_ready (≥10k cycles) against a reference queue model → output sequence matches, count always ≤2, and no acc ever occurs while in_ready=0.
- WIDTH=8, BUBBLE=8'hA5: flush → out_data=8'hA5 with out_valid=0.
